// File: rtl/rr_mux_pkg.sv
// Shared types and constants for the round-robin N:1 mux.
package rr_mux_pkg;

  localparam logic MODE_AUTO   = 1'b0;
  localparam logic MODE_MANUAL = 1'b1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping modulo NCH.
module rr_arbiter #(
  parameter  int unsigned NCH  = 8,
  localparam int unsigned SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_any
);

  int unsigned     idx;
  logic [SELW-1:0] idx_s;

  // Scan from the farthest offset down so the nearest requester after ptr wins last.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    idx_s   = '0;
    for (int unsigned k = NCH; k > 0; k--) begin
      idx = 32'(ptr) + k - 1;
      if (idx >= NCH) idx = idx - NCH;
      idx_s = SELW'(idx);
      if (req[idx_s]) begin
        gnt_idx = idx_s;
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_mux_nx1.sv
// N:1 valid/ready mux with registered output, auto round-robin or manual channel select.
// Define RR_MUX_PARITY_EN to add the registered even-parity output y_par.
module rr_mux_nx1
  import rr_mux_pkg::*;
#(
  parameter  int unsigned NCH  = 8,
  parameter  int unsigned W    = 8,
  localparam int unsigned SELW = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH*W-1:0] in_data,
  input  logic [NCH-1:0]   in_valid,
  output logic [NCH-1:0]   in_ready,
  input  logic             mode,
  input  logic [SELW-1:0]  man_sel,
  output logic [W-1:0]     y,
  output logic [SELW-1:0]  y_sel,
  output logic             y_valid,
  input  logic             y_ready
`ifdef RR_MUX_PARITY_EN
  ,
  output logic             y_par
`endif
);

  localparam int unsigned NSEL = 1 << SELW;

  out_state_e      state_q, state_d;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [W-1:0]    y_q, y_d;
  logic [SELW-1:0] y_sel_q, y_sel_d;

  logic            load_c;
  logic            gnt_c;
  logic [SELW-1:0] gnt_idx_c;
  logic [W-1:0]    gnt_data_c;
  logic            arb_any;
  logic [SELW-1:0] arb_idx;
  logic [NSEL-1:0] valid_ext;
  logic            man_hit;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req     (in_valid),
    .ptr     (ptr_q),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

  // Zero-extending to a power of two makes an out-of-range man_sel see no request.
  assign valid_ext = NSEL'(in_valid);
  assign man_hit   = valid_ext[man_sel];
  assign load_c    = (state_q == EMPTY) || y_ready;

  always_comb begin
    gnt_c     = 1'b0;
    gnt_idx_c = '0;
    if (mode == MODE_MANUAL) begin
      gnt_c     = load_c & man_hit;
      gnt_idx_c = man_sel;
    end else begin
      gnt_c     = load_c & arb_any;
      gnt_idx_c = arb_idx;
    end
  end

  always_comb begin
    gnt_data_c = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (gnt_idx_c == SELW'(i)) gnt_data_c = in_data[i*W +: W];
    end
  end

  // Output FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Output FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (gnt_c) state_d = FULL;
      FULL:    if (y_ready && !gnt_c) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Output FSM: accept strobe, one-hot on the granted channel
  always_comb begin
    in_ready = '0;
    if (gnt_c) in_ready = NCH'(1) << gnt_idx_c;
  end

  always_comb begin
    y_d     = y_q;
    y_sel_d = y_sel_q;
    ptr_d   = ptr_q;
    if (gnt_c) begin
      y_d     = gnt_data_c;
      y_sel_d = gnt_idx_c;
      if (mode == MODE_AUTO)
        ptr_d = (gnt_idx_c == SELW'(NCH - 1)) ? '0 : gnt_idx_c + SELW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q     <= '0;
      y_sel_q <= '0;
      ptr_q   <= '0;
    end else begin
      y_q     <= y_d;
      y_sel_q <= y_sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign y       = y_q;
  assign y_sel   = y_sel_q;
  assign y_valid = (state_q == FULL);

`ifdef RR_MUX_PARITY_EN
  logic y_par_q, y_par_d;

  assign y_par_d = gnt_c ? ^gnt_data_c : y_par_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) y_par_q <= 1'b0;
    else        y_par_q <= y_par_d;
  end

  assign y_par = y_par_q;
`endif

endmodule

// File: tb/tb_rr_mux_nx1.sv
// Directed bench for rr_mux_nx1 (NCH=8, W=8); parity checks active with RR_MUX_PARITY_EN.
module tb_rr_mux_nx1;

  localparam int unsigned NCH  = 8;
  localparam int unsigned W    = 8;
  localparam int unsigned SELW = 3;

  logic             clk;
  logic             rst_n;
  logic [NCH*W-1:0] in_data;
  logic [NCH-1:0]   in_valid;
  logic [NCH-1:0]   in_ready;
  logic             mode;
  logic [SELW-1:0]  man_sel;
  logic [W-1:0]     y;
  logic [SELW-1:0]  y_sel;
  logic             y_valid;
  logic             y_ready;
`ifdef RR_MUX_PARITY_EN
  logic             y_par;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  rr_mux_nx1 #(.NCH(NCH), .W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mode     (mode),
    .man_sel  (man_sel),
    .y        (y),
    .y_sel    (y_sel),
    .y_valid  (y_valid),
    .y_ready  (y_ready)
`ifdef RR_MUX_PARITY_EN
    ,
    .y_par    (y_par)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input logic [7:0] base);
    for (int i = 0; i < NCH; i++) in_data[i*W +: W] = base + 8'(i);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_data  = '0;
    in_valid = '0;
    mode     = 1'b0;
    man_sel  = '0;
    y_ready  = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_y_valid", 32'(y_valid), 0);
    chk("rst_y", 32'(y), 0);
    chk("rst_y_sel", 32'(y_sel), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
`ifdef RR_MUX_PARITY_EN
    chk("rst_y_par", 32'(y_par), 0);
`endif
    rst_n = 1'b1;

    // Auto mode, all channels requesting: A0..A7 then wrap to A0
    set_data(8'hA0);
    in_valid = 8'hFF;
    y_ready  = 1'b1;
    for (int k = 0; k < 9; k++) begin
      #1;
      chk("rr_in_ready", 32'(in_ready), 32'(1) << (k % 8));
      tick();
      chk("rr_y", 32'(y), 'hA0 + (k % 8));
      chk("rr_y_sel", 32'(y_sel), k % 8);
      chk("rr_y_valid", 32'(y_valid), 1);
    end

    // ptr is 1: a lone request on channel 2 leaves ptr at 3
    in_valid = 8'h04;
    #1;
    chk("ptr3_setup_ready", 32'(in_ready), 'h04);
    tick();
    chk("ptr3_setup_y", 32'(y), 'hA2);

    // ptr 3, requests on 7 and 2: grant 7 then 2
    in_valid = 8'b1000_0100;
    #1;
    chk("sparse_ready_7", 32'(in_ready), 'h80);
    tick();
    chk("sparse_y_7", 32'(y), 'hA7);
    chk("sparse_sel_7", 32'(y_sel), 7);
    #1;
    chk("sparse_ready_2", 32'(in_ready), 'h04);
    tick();
    chk("sparse_y_2", 32'(y), 'hA2);
    chk("sparse_sel_2", 32'(y_sel), 2);

    // Manual select channel 5 with everyone requesting
    mode     = 1'b1;
    man_sel  = 3'd5;
    in_valid = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("man_in_ready", 32'(in_ready), 'h20);
      tick();
      chk("man_y", 32'(y), 'hA5);
      chk("man_y_sel", 32'(y_sel), 5);
      chk("man_y_valid", 32'(y_valid), 1);
    end

    // Selected channel idle: held word drains, nothing else served
    in_valid = 8'hDF;
    #1;
    chk("man_idle_ready", 32'(in_ready), 0);
    tick();
    chk("man_idle_valid", 32'(y_valid), 0);

    // Auto grant from ptr 3 (manual grants left ptr alone), then stall
    mode     = 1'b0;
    y_ready  = 1'b0;
    in_valid = 8'hFF;
    #1;
    chk("stall_load_ready", 32'(in_ready), 'h08);
    tick();
    chk("stall_load_y", 32'(y), 'hA3);
    chk("stall_load_valid", 32'(y_valid), 1);
    for (int c = 0; c < 4; c++) begin
      set_data(8'h10 + 8'(c * 16));
      in_valid = (c % 2 == 0) ? 8'h5A : 8'hFF;
      mode     = (c == 2) ? 1'b1 : 1'b0;
      man_sel  = 3'd0;
      #1;
      chk("stall_in_ready", 32'(in_ready), 0);
      tick();
      chk("stall_y", 32'(y), 'hA3);
      chk("stall_y_sel", 32'(y_sel), 3);
      chk("stall_y_valid", 32'(y_valid), 1);
    end

    // Release: accept held word and load channel 4 in the same cycle
    set_data(8'h50);
    mode     = 1'b0;
    in_valid = 8'hFF;
    y_ready  = 1'b1;
    #1;
    chk("release_ready", 32'(in_ready), 'h10);
    tick();
    chk("release_y", 32'(y), 'h54);
    chk("release_sel", 32'(y_sel), 4);
    chk("release_valid", 32'(y_valid), 1);

    // Asynchronous reset while FULL
    y_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(y_valid), 0);
    chk("async_rst_y", 32'(y), 0);
    chk("async_rst_sel", 32'(y_sel), 0);
    tick();
    rst_n = 1'b1;

    // ptr back to 0 after reset; channel 0 carries 8'h07
    set_data(8'h50);
    in_data[7:0] = 8'h07;
    in_valid     = 8'hFF;
    y_ready      = 1'b1;
    #1;
    chk("post_rst_ready", 32'(in_ready), 'h01);
    tick();
    chk("post_rst_y", 32'(y), 'h07);
    chk("post_rst_sel", 32'(y_sel), 0);
`ifdef RR_MUX_PARITY_EN
    chk("par_y07", 32'(y_par), 1);
    #1;
    tick();
    chk("par_y51", 32'(y_par), 1);
    tick();
    chk("par_y52", 32'(y_par), 1);
    tick();
    chk("par_y53", 32'(y_par), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
